byte_lane_packer: RTL

//   Write-side feeder for the team's byte-enabled 16-bit registers.

---
 rtl/byte_lane_pkg.sv | 21 ++
 rtl/byte_lane_packer.sv | 94 +++++++++
 2 files changed

// File: rtl/byte_lane_pkg.sv
// Shared lane-packing types and defaults for the byte-enabled register write path.
package byte_lane_pkg;

    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned DEF_LANES  = 2;

    typedef logic [DEF_LANES-1:0] byteena_t;

    localparam byteena_t BE_FULL = '1;

    // Mask with the low n lanes set; n >= DEF_LANES yields BE_FULL.
    function automatic byteena_t lane_mask(input int unsigned n);
        byteena_t m;
        m = '0;
        for (int unsigned i = 0; i < DEF_LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Packs a valid/ready byte stream into LANES-byte words with a contiguous byteena mask;
// in_last closes a short word early.
module byte_lane_packer
    import byte_lane_pkg::*;
#(
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned LANES  = DEF_LANES
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*LANES-1:0]  out_data,
    output logic [LANES-1:0]         out_byteena,
    output logic                     out_last,
    output logic [15:0]              word_count
);

    localparam int unsigned WORD_W = BYTE_W * LANES;
    localparam int unsigned PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

    logic [PTR_W-1:0]  lane_ptr;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [WORD_W-1:0] word_masked;
    logic [LANES-1:0]  mask;
    logic [LANES-1:0]  mask_next;
    logic              in_fire;
    logic              out_fire;
    logic              complete;

    // Ready only looks at the output slot, never at in_valid/in_data.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign complete = in_fire && ((lane_ptr == PTR_LAST) || in_last);

    // Accumulator and mask as they would look with the current byte merged in.
    always_comb begin
        acc_next    = acc;
        mask_next   = mask;
        word_masked = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (PTR_W'(k) == lane_ptr) begin
                acc_next[k*BYTE_W +: BYTE_W] = in_data;
                mask_next[k]                 = 1'b1;
            end
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            if (mask_next[k]) begin
                word_masked[k*BYTE_W +: BYTE_W] = acc_next[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Accumulator, lane pointer, output word register and transfer counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lane_ptr    <= '0;
            acc         <= '0;
            mask        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_byteena <= '0;
            out_last    <= 1'b0;
            word_count  <= '0;
        end else begin
            if (out_fire) begin
                out_valid  <= 1'b0;
                word_count <= word_count + 16'd1;
            end
            if (complete) begin
                // A completing word overrides the clear above, giving bubble-free reload.
                out_valid   <= 1'b1;
                out_data    <= word_masked;
                out_byteena <= mask_next;
                out_last    <= in_last;
                acc         <= '0;
                mask        <= '0;
                lane_ptr    <= '0;
            end else if (in_fire) begin
                acc      <= acc_next;
                mask     <= mask_next;
                lane_ptr <= lane_ptr + PTR_W'(1);
            end
        end
    end

endmodule
